// File: rtl/mem_pkg.sv
// Shared encodings for the LSU memory master: access sizes, FSM states and lane-mask helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    function automatic logic [7:0] byte_mask(input size_e size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // Natural alignment: the low 'size' address bits must be zero.
    function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/mask shift-up and load extract with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [2:0]  off_i,
    input  logic        signed_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rbeat_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wmask_o,
    output logic [63:0] rdata_o
);

    logic [63:0] rshift;

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign wmask_o = byte_mask(size_i, off_i);
    assign rshift  = rbeat_i >> {off_i, 3'b000};

    always_comb begin
        rdata_o = rshift;
        case (size_i)
            SZ_B:    rdata_o = {{56{signed_i & rshift[7]}},  rshift[7:0]};
            SZ_H:    rdata_o = {{48{signed_i & rshift[15]}}, rshift[15:0]};
            SZ_W:    rdata_o = {{32{signed_i & rshift[31]}}, rshift[31:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator on the ioMem_* port: aligns requests to a 64-bit beat,
// waits for the responder, and returns extended load data or an error.
module lsu_mem_master
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ioMem_ren,
    output logic [ADDR_W-1:0] ioMem_addr,
    input  logic [DATA_W-1:0] ioMem_rData,
    input  logic              ioMem_rvalid,
    input  logic              ioMem_hit,
    output logic              ioMem_wen,
    output logic [DATA_W-1:0] ioMem_wData,
    output logic [7:0]        ioMem_wMask
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    size_e               size_q;
    logic                signed_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ready_q;
    logic                ren_q;
    logic                wen_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [63:0]         align_wdata;
    logic [7:0]          align_wmask;
    logic [63:0]         align_rdata;

    mem_lane_align u_align (
        .size_i   (size_q),
        .off_i    (addr_q[2:0]),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .rbeat_i  (ioMem_rData),
        .wdata_o  (align_wdata),
        .wmask_o  (align_wmask),
        .rdata_o  (align_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= SZ_B;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        size_q   <= size_e'(req_size);
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata;
                        ready_q  <= 1'b0;
                        if (is_misaligned(size_e'(req_size), req_addr[2:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            rdata_q      <= '0;
                        end else if (req_wr) begin
                            state_q <= ST_WR;
                            wen_q   <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            ren_q   <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (ioMem_hit) begin
                        state_q <= ST_WAIT;
                        ren_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ioMem_rvalid) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= align_rdata;
                    end else if (TIMEOUT != 0 && CNT_W'(cnt_q + 1'b1) == TO_LIM) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        rdata_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WR: begin
                    if (ioMem_hit) begin
                        state_q      <= ST_RESP;
                        wen_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= '0;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    rdata_q      <= '0;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    // Store lanes are only driven while the write strobe is up.
    assign ioMem_wData = wen_q ? align_wdata : '0;
    assign ioMem_wMask = wen_q ? align_wmask : 8'h00;
    assign ioMem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign ioMem_ren   = ren_q;
    assign ioMem_wen   = wen_q;
    assign req_ready   = ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: loads, stores, misalignment, hit stalls, timeout and reset abort.
module tb_lsu_mem_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        ioMem_ren;
    logic [31:0] ioMem_addr;
    logic [63:0] ioMem_rData;
    logic        ioMem_rvalid;
    logic        ioMem_hit;
    logic        ioMem_wen;
    logic [63:0] ioMem_wData;
    logic [7:0]  ioMem_wMask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    lsu_mem_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ioMem_ren    (ioMem_ren),
        .ioMem_addr   (ioMem_addr),
        .ioMem_rData  (ioMem_rData),
        .ioMem_rvalid (ioMem_rvalid),
        .ioMem_hit    (ioMem_hit),
        .ioMem_wen    (ioMem_wen),
        .ioMem_wData  (ioMem_wData),
        .ioMem_wMask  (ioMem_wMask)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for a single cycle; returns in cycle 1 after accept.
    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [63:0] beat, input logic [63:0] exp);
        ioMem_hit = 1'b1;
        issue(tag, 1'b0, addr, size, sgn, 64'd0);
        check({tag, "_ren1"}, 64'(ioMem_ren), 64'd1);
        check({tag, "_addr"}, 64'(ioMem_addr), 64'({addr[31:3], 3'b000}));
        check({tag, "_wen1"}, 64'(ioMem_wen), 64'd0);
        tick();
        check({tag, "_ren2"}, 64'(ioMem_ren), 64'd0);
        check({tag, "_early"}, 64'(resp_valid), 64'd0);
        ioMem_rvalid = 1'b1;
        ioMem_rData  = beat;
        tick();
        ioMem_rvalid = 1'b0;
        ioMem_rData  = 64'd0;
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_rdata"}, resp_rdata, exp);
        check({tag, "_err"}, 64'(resp_err), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
        $display("[TB] load  %-6s addr=%h size=%0d signed=%0d -> rdata=%h", tag, addr, size, sgn, exp);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [63:0] wdata, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata);
        ioMem_hit = 1'b1;
        issue(tag, 1'b1, addr, size, 1'b0, wdata);
        check({tag, "_wen1"}, 64'(ioMem_wen), 64'd1);
        check({tag, "_ren1"}, 64'(ioMem_ren), 64'd0);
        check({tag, "_mask"}, 64'(ioMem_wMask), 64'(exp_mask));
        check({tag, "_wdata"}, ioMem_wData, exp_wdata);
        check({tag, "_addr"}, 64'(ioMem_addr), 64'({addr[31:3], 3'b000}));
        tick();
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_err"}, 64'(resp_err), 64'd0);
        check({tag, "_rdata"}, resp_rdata, 64'd0);
        check({tag, "_wen2"}, 64'(ioMem_wen), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
        $display("[TB] store %-6s addr=%h size=%0d mask=%h wdata=%h", tag, addr, size, exp_mask, exp_wdata);
    endtask

    task automatic do_misaligned(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size);
        ioMem_hit = 1'b1;
        issue(tag, wr, addr, size, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_err"}, 64'(resp_err), 64'd1);
        check({tag, "_ren"}, 64'(ioMem_ren), 64'd0);
        check({tag, "_wen"}, 64'(ioMem_wen), 64'd0);
        check({tag, "_rdata"}, resp_rdata, 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
        check({tag, "_ren2"}, 64'(ioMem_ren), 64'd0);
        check({tag, "_wen2"}, 64'(ioMem_wen), 64'd0);
        $display("[TB] misal %-6s addr=%h size=%0d wr=%0d -> err", tag, addr, size, wr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'd0;
        req_signed   = 1'b0;
        req_wdata    = 64'd0;
        ioMem_rData  = 64'd0;
        ioMem_rvalid = 1'b0;
        ioMem_hit    = 1'b0;
        repeat (3) tick();

        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_err",   64'(resp_err), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_ren",   64'(ioMem_ren), 64'd0);
        check("rst_wen",   64'(ioMem_wen), 64'd0);
        check("rst_addr",  64'(ioMem_addr), 64'd0);
        check("rst_wmask", 64'(ioMem_wMask), 64'd0);
        check("rst_wdata", ioMem_wData, 64'd0);
        $display("[TB] reset state checked");
        reset = 1'b0;
        tick();

        do_load("lw",  32'h8000_0004, 2'd2, 1'b1, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
        do_load("lbu", 32'h8000_0007, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);
        do_load("lb",  32'h8000_0007, 2'd0, 1'b1, 64'hAB00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFAB);
        do_load("lhu", 32'h8000_0006, 2'd1, 1'b0, 64'h9ABC_0000_0000_0000, 64'h0000_0000_0000_9ABC);
        do_load("lh",  32'h8000_0002, 2'd1, 1'b1, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF);
        do_load("ld",  32'h8000_0008, 2'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        do_store("sh", 32'h8000_0002, 2'd1, 64'h0000_0000_0000_BEEF, 8'h0C, 64'h0000_0000_BEEF_0000);
        do_store("sb", 32'h8000_0005, 2'd0, 64'h0000_0000_0000_005A, 8'h20, 64'h0000_5A00_0000_0000);
        do_store("sd", 32'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);

        do_misaligned("mld", 1'b0, 32'h8000_0004, 2'd3);
        do_misaligned("msw", 1'b1, 32'h8000_0002, 2'd2);

        // Responder refuses the read for three cycles; ren and addr must hold.
        ioMem_hit = 1'b0;
        issue("stall", 1'b0, 32'h8000_0010, 2'd3, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ren", 64'(ioMem_ren), 64'd1);
            check("stall_addr", 64'(ioMem_addr), 64'h8000_0010);
            check("stall_valid", 64'(resp_valid), 64'd0);
            tick();
        end
        ioMem_hit = 1'b1;
        check("stall_ren4", 64'(ioMem_ren), 64'd1);
        tick();
        check("stall_ren5", 64'(ioMem_ren), 64'd0);
        ioMem_rvalid = 1'b1;
        ioMem_rData  = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        ioMem_rvalid = 1'b0;
        ioMem_rData  = 64'd0;
        check("stall_valid6", 64'(resp_valid), 64'd1);
        check("stall_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check("stall_ready", 64'(req_ready), 64'd1);
        $display("[TB] stall 3 cycles of hit=0 -> rdata=%h", 64'hDEAD_BEEF_CAFE_F00D);

        // No rvalid ever: four WAIT cycles then an error response.
        ioMem_hit = 1'b1;
        issue("tmo", 1'b0, 32'h8000_0020, 2'd2, 1'b0, 64'd0);
        check("tmo_ren", 64'(ioMem_ren), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait", 64'(resp_valid), 64'd0);
            tick();
        end
        check("tmo_valid", 64'(resp_valid), 64'd1);
        check("tmo_err", 64'(resp_err), 64'd1);
        check("tmo_rdata", resp_rdata, 64'd0);
        tick();
        check("tmo_ready", 64'(req_ready), 64'd1);
        $display("[TB] timeout after 4 wait cycles -> err");

        // Reset while waiting; the late beat must not produce a response.
        issue("rstw", 1'b0, 32'h8000_0030, 2'd3, 1'b0, 64'd0);
        tick();
        check("rstw_inwait", 64'(ioMem_ren), 64'd0);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        ioMem_rvalid = 1'b1;
        ioMem_rData  = 64'h5555_AAAA_5555_AAAA;
        check("rstw_valid1", 64'(resp_valid), 64'd0);
        check("rstw_ready1", 64'(req_ready), 64'd1);
        tick();
        ioMem_rvalid = 1'b0;
        ioMem_rData  = 64'd0;
        check("rstw_valid2", 64'(resp_valid), 64'd0);
        check("rstw_ready2", 64'(req_ready), 64'd1);
        check("rstw_ren", 64'(ioMem_ren), 64'd0);
        tick();
        check("rstw_valid3", 64'(resp_valid), 64'd0);
        $display("[TB] reset during wait -> aborted, no response");

        do_load("post", 32'h8000_0004, 2'd2, 1'b0, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
